core_reg_writeback: RTL and testbench
=====================================

CORE_REG_WRITEBACK -- requirements
Module: core_reg_writeback

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: clk in 1, rising-edge clock; rst in 1, asynchronous active-high reset.
REQ-002 The ALU result port SHALL be: alu_valid in 1, result offered; alu_rd in reg_num, destination; alu_value in word, result; alu_discard in 1, forward-only result with no file update; alu_ready out 1, result accepted this cycle.
REQ-003 The load result port SHALL be: mem_valid in 1; mem_rd in reg_num; mem_value in word; mem_ready out 1, with the same meanings as the ALU port.
REQ-004 The scoreboard claim port SHALL be: claim_valid in 1, issue reserves a destination; claim_r in reg_num; claim_ready out 1, reservation accepted.
REQ-005 The scoreboard query port SHALL be: query_r in reg_num; query_busy out 1, register has a pending write.
REQ-006 The register-file write port SHALL be: wr_r out reg_num; wr_enable out 1, write or forward candidate; wr_enable_file out 1, commit to file; wr_value out word; wr_current out word, forward value.

Function
REQ-007 Arbitration SHALL grant at most one source per cycle; a handshake occurs when valid and ready are both high.
REQ-008 The load port SHALL have priority, except that after 2 consecutive cycles in which alu_valid was high and not granted, the ALU SHALL be granted on the next cycle it is valid.
REQ-009 The starvation counter SHALL be 2 bits, clear on any ALU grant or when alu_valid is low, and saturate at 2.
REQ-010 alu_ready and mem_ready SHALL be combinational functions of both valid inputs and the starvation counter only.
REQ-011 A grant in cycle N SHALL produce wr_enable=1 with the granted wr_r and wr_value in cycle N+1, giving a registered one-cycle latency.
REQ-012 wr_current SHALL equal wr_value at all times.
REQ-013 wr_enable_file SHALL equal wr_enable AND NOT the registered discard flag; load results SHALL never be discards.
REQ-014 In a cycle with no grant, wr_enable and wr_enable_file SHALL be 0 in the next cycle, and wr_r/wr_value SHALL hold their previous values.
REQ-015 The scoreboard SHALL hold busy[NUM_GPREGS]; claim_ready SHALL be 1 if and only if busy[claim_r] is 0, or busy[claim_r] is being cleared this cycle.
REQ-016 An accepted claim SHALL set busy[claim_r] at the next edge.
REQ-017 A cycle with wr_enable=1 SHALL clear busy[wr_r] at the next edge, including discards.
REQ-018 When a claim and a clear target the same register in the same cycle, the claim SHALL win and busy SHALL remain 1.
REQ-019 query_busy SHALL be combinational from busy[query_r] and SHALL NOT reflect same-cycle claims or clears.
REQ-020 A write to a register that is not busy SHALL still be performed, and busy SHALL remain 0.

Reset
REQ-021 Asserting rst SHALL asynchronously force wr_enable=0, wr_enable_file=0, wr_r=0, wr_value=0, all busy bits=0, and the starvation counter=0.
REQ-022 A grant in flight when rst is asserted SHALL be lost; no write SHALL appear after rst is released.
REQ-023 While rst is high, alu_ready, mem_ready and claim_ready SHALL be 0.

Structure
REQ-024 The types word and reg_num, and the constant NUM_GPREGS, SHALL come from the shared core microarchitecture package; the block SHALL NOT define local copies.
REQ-025 The scoreboard SHALL be a sub-module, core_reg_scoreboard, holding the busy bits and the claim/clear/query logic; arbitration and the output registers SHALL stay in the top module.

Verification
REQ-026 Bench case, load only: mem_valid=1, mem_rd=5, mem_value=0xDEADBEEF in cycle 0 -> wr_enable=1, wr_enable_file=1, wr_r=5, wr_value=wr_current=0xDEADBEEF in cycle 1, and nothing in cycle 2.
REQ-027 Bench case, both sources valid continuously -> grants in the order mem, mem, alu, mem, mem, alu; alu_ready high only on every third cycle.
REQ-028 Bench case, ALU discard: alu_valid=1, alu_rd=3, alu_discard=1 -> next cycle wr_enable=1 and wr_enable_file=0; busy[3] is cleared.
REQ-029 Bench case, scoreboard: claim r7 in cycle 0 -> query_busy(7)=1 in cycle 1 and claim_ready=0 for r7; write r7 -> busy cleared the following cycle; a claim of r7 concurrent with the clear -> busy stays 1.
REQ-030 Bench case, reset mid-operation: assert rst between an alu handshake and the following edge -> wr_enable stays 0, all busy bits read 0, and no stale write appears after release.

Source files
------------

// File: rtl/core_reg_writeback_pkg.sv
// Shared core microarchitecture types for the register writeback slice.
//   word        - architectural data word
//   reg_num     - general-purpose register index
//   NUM_GPREGS  - number of general-purpose registers
//   wb_entry_t  - contents of the writeback output register
package core_reg_writeback_pkg;

    localparam int NUM_GPREGS = 32;
    localparam int WORD_W     = 32;

    typedef logic [WORD_W-1:0]             word;
    typedef logic [$clog2(NUM_GPREGS)-1:0] reg_num;

    // Consecutive lost ALU arbitrations before the ALU is forced through.
    localparam logic [1:0] STARVE_LIMIT = 2'd2;

    typedef struct packed {
        reg_num r;
        word    value;
        logic   discard;
    } wb_entry_t;

endpackage

// File: rtl/core_reg_writeback_if.sv
// Bundle of the writeback block's handshake and bus signals.
//   alu_*    - ALU result port (valid/ready, rd, value, discard)
//   mem_*    - load result port (valid/ready, rd, value)
//   claim_*  - scoreboard reservation port
//   query_*  - scoreboard busy lookup
//   wr_*     - register-file write / forward port
// master drives results, claims and queries; slave is the writeback block.
interface core_reg_writeback_if;
    import core_reg_writeback_pkg::*;

    logic   alu_valid;
    reg_num alu_rd;
    word    alu_value;
    logic   alu_discard;
    logic   alu_ready;

    logic   mem_valid;
    reg_num mem_rd;
    word    mem_value;
    logic   mem_ready;

    logic   claim_valid;
    reg_num claim_r;
    logic   claim_ready;

    reg_num query_r;
    logic   query_busy;

    reg_num wr_r;
    logic   wr_enable;
    logic   wr_enable_file;
    word    wr_value;
    word    wr_current;

    modport master (
        output alu_valid, alu_rd, alu_value, alu_discard,
        output mem_valid, mem_rd, mem_value,
        output claim_valid, claim_r, query_r,
        input  alu_ready, mem_ready, claim_ready, query_busy,
        input  wr_r, wr_enable, wr_enable_file, wr_value, wr_current
    );

    modport slave (
        input  alu_valid, alu_rd, alu_value, alu_discard,
        input  mem_valid, mem_rd, mem_value,
        input  claim_valid, claim_r, query_r,
        output alu_ready, mem_ready, claim_ready, query_busy,
        output wr_r, wr_enable, wr_enable_file, wr_value, wr_current
    );

endinterface

// File: rtl/core_reg_writeback_scoreboard.sv
// Pending-write scoreboard: one busy bit per general-purpose register.
//   clk, rst     - clock, async active-high reset
//   claim_*      - issue reserves a destination (set busy)
//   clr_en/clr_r - writeback of a register this cycle (clear busy)
//   query_r/busy - registered busy lookup, no same-cycle bypass
module core_reg_scoreboard
    import core_reg_writeback_pkg::*;
(
    input  logic   clk,
    input  logic   rst,
    input  logic   claim_valid,
    input  reg_num claim_r,
    output logic   claim_ready,
    input  logic   clr_en,
    input  reg_num clr_r,
    input  reg_num query_r,
    output logic   query_busy
);

    logic [NUM_GPREGS-1:0] busy;
    logic [NUM_GPREGS-1:0] busy_nxt;
    logic                  claim_fire;

    // A register being written back this cycle is free again at the edge,
    // so a new reservation of it can be accepted now.
    assign claim_ready = !rst && (!busy[claim_r] || (clr_en && clr_r == claim_r));
    assign claim_fire  = claim_valid && claim_ready;
    assign query_busy  = busy[query_r];

    // Claim is applied after the clear so a same-register collision stays busy.
    always_comb begin
        busy_nxt = busy;
        if (clr_en)
            busy_nxt[clr_r] = 1'b0;
        if (claim_fire)
            busy_nxt[claim_r] = 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            busy <= '0;
        else
            busy <= busy_nxt;
    end

endmodule

// File: rtl/core_reg_writeback.sv
// Register writeback: arbitrates ALU and load results onto one register-file
// write port with a one-cycle registered latency, and tracks pending writes.
//   clk - rising-edge clock
//   rst - asynchronous active-high reset
//   bus - core_reg_writeback_if.slave (result ports, claim/query, write port)
module core_reg_writeback
    import core_reg_writeback_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    core_reg_writeback_if.slave  bus
);

    logic      [1:0] starve;
    logic            alu_force;
    logic            alu_gnt;
    logic            mem_gnt;
    logic            wb_vld;
    wb_entry_t       wb_q;

    // Loads win unless the ALU has lost STARVE_LIMIT cycles in a row.
    assign alu_force = (starve == STARVE_LIMIT);
    assign alu_gnt   = !rst && bus.alu_valid && (!bus.mem_valid || alu_force);
    assign mem_gnt   = !rst && bus.mem_valid && !(bus.alu_valid && alu_force);

    assign bus.alu_ready = alu_gnt;
    assign bus.mem_ready = mem_gnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            starve <= '0;
        else if (!bus.alu_valid || alu_gnt)
            starve <= '0;
        else if (starve != STARVE_LIMIT)
            starve <= starve + 2'd1;
    end

    // Output register; r/value hold when idle, only the valid bit drops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_vld <= 1'b0;
            wb_q   <= '0;
        end else begin
            wb_vld <= alu_gnt || mem_gnt;
            if (alu_gnt)
                wb_q <= '{r: bus.alu_rd, value: bus.alu_value, discard: bus.alu_discard};
            else if (mem_gnt)
                wb_q <= '{r: bus.mem_rd, value: bus.mem_value, discard: 1'b0};
        end
    end

    assign bus.wr_r           = wb_q.r;
    assign bus.wr_value       = wb_q.value;
    assign bus.wr_current     = wb_q.value;
    assign bus.wr_enable      = wb_vld;
    assign bus.wr_enable_file = wb_vld && !wb_q.discard;

    // Discards still retire the reservation, hence clear on wr_enable.
    core_reg_scoreboard u_sb (
        .clk         (clk),
        .rst         (rst),
        .claim_valid (bus.claim_valid),
        .claim_r     (bus.claim_r),
        .claim_ready (bus.claim_ready),
        .clr_en      (wb_vld),
        .clr_r       (wb_q.r),
        .query_r     (bus.query_r),
        .query_busy  (bus.query_busy)
    );

endmodule

// File: tb/tb_core_reg_writeback.sv
// Directed bench for core_reg_writeback. Stimulus pushes the hand-computed
// write it expects into a queue; a negedge monitor pops and compares every
// write the DUT presents.
module tb_core_reg_writeback;
    import core_reg_writeback_pkg::*;

    typedef struct {
        reg_num r;
        word    v;
        logic   file;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_pass  = 0;
    int   n_total = 0;
    exp_t exp_q[$];

    core_reg_writeback_if bus ();

    core_reg_writeback dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
        n_total++;
        if (act === want)
            n_pass++;
        else
            $display("FAIL %s: got %h want %h", name, act, want);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Write monitor / scoreboard checker.
    always @(negedge clk) begin
        if (!rst && bus.wr_enable === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", {27'd0, bus.wr_r}, 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("wr_r", {27'd0, bus.wr_r}, {27'd0, e.r});
                chk("wr_value", bus.wr_value, e.v);
                chk("wr_current", bus.wr_current, e.v);
                chk("wr_enable_file", {31'd0, bus.wr_enable_file}, {31'd0, e.file});
            end
        end
    end

    initial begin
        logic alu_exp;
        int   busy_cnt;
        bus.alu_valid = 0; bus.alu_rd = '0; bus.alu_value = '0; bus.alu_discard = 0;
        bus.mem_valid = 0; bus.mem_rd = '0; bus.mem_value = '0;
        bus.claim_valid = 0; bus.claim_r = '0; bus.query_r = '0;

        // Reset state, readies held low with all requests asserted.
        repeat (2) @(posedge clk);
        #1;
        bus.alu_valid = 1; bus.mem_valid = 1; bus.claim_valid = 1;
        #1;
        chk("rst_alu_ready", {31'd0, bus.alu_ready}, 32'd0);
        chk("rst_mem_ready", {31'd0, bus.mem_ready}, 32'd0);
        chk("rst_claim_ready", {31'd0, bus.claim_ready}, 32'd0);
        chk("rst_wr_enable", {31'd0, bus.wr_enable}, 32'd0);
        chk("rst_wr_enable_file", {31'd0, bus.wr_enable_file}, 32'd0);
        chk("rst_wr_r", {27'd0, bus.wr_r}, 32'd0);
        chk("rst_wr_value", bus.wr_value, 32'd0);
        bus.alu_valid = 0; bus.mem_valid = 0; bus.claim_valid = 0;
        rst = 0;
        cyc();

        // Load only.
        bus.mem_valid = 1; bus.mem_rd = 5'd5; bus.mem_value = 32'hDEAD_BEEF;
        #1 chk("load_mem_ready", {31'd0, bus.mem_ready}, 32'd1);
        exp_q.push_back('{r: 5'd5, v: 32'hDEAD_BEEF, file: 1'b1});
        cyc();
        bus.mem_valid = 0;
        #1 chk("load_wr_enable_c1", {31'd0, bus.wr_enable}, 32'd1);
        cyc();
        chk("load_wr_enable_c2", {31'd0, bus.wr_enable}, 32'd0);
        chk("load_hold_wr_r", {27'd0, bus.wr_r}, 32'd5);
        chk("load_hold_wr_value", bus.wr_value, 32'hDEAD_BEEF);

        // Both valid continuously: mem, mem, alu, mem, mem, alu.
        for (int i = 0; i < 6; i++) begin
            alu_exp = (i % 3 == 2);
            bus.alu_valid = 1; bus.alu_rd = 5'd2; bus.alu_value = 32'h200 + i; bus.alu_discard = 0;
            bus.mem_valid = 1; bus.mem_rd = 5'd1; bus.mem_value = 32'h100 + i;
            #1;
            chk("arb_alu_ready", {31'd0, bus.alu_ready}, {31'd0, alu_exp});
            chk("arb_mem_ready", {31'd0, bus.mem_ready}, {31'd0, !alu_exp});
            if (alu_exp)
                exp_q.push_back('{r: 5'd2, v: 32'h200 + i, file: 1'b1});
            else
                exp_q.push_back('{r: 5'd1, v: 32'h100 + i, file: 1'b1});
            cyc();
        end
        bus.alu_valid = 0; bus.mem_valid = 0;
        cyc();

        // ALU discard clears a pending reservation but skips the file.
        bus.claim_valid = 1; bus.claim_r = 5'd3;
        #1 chk("disc_claim_ready", {31'd0, bus.claim_ready}, 32'd1);
        cyc();
        bus.claim_valid = 0; bus.query_r = 5'd3;
        bus.alu_valid = 1; bus.alu_rd = 5'd3; bus.alu_value = 32'h0000_0333; bus.alu_discard = 1;
        #1;
        chk("disc_busy_before", {31'd0, bus.query_busy}, 32'd1);
        chk("disc_alu_ready", {31'd0, bus.alu_ready}, 32'd1);
        exp_q.push_back('{r: 5'd3, v: 32'h0000_0333, file: 1'b0});
        cyc();
        bus.alu_valid = 0; bus.alu_discard = 0;
        #1;
        chk("disc_wr_enable", {31'd0, bus.wr_enable}, 32'd1);
        chk("disc_wr_enable_file", {31'd0, bus.wr_enable_file}, 32'd0);
        cyc();
        chk("disc_busy_cleared", {31'd0, bus.query_busy}, 32'd0);

        // Scoreboard on r7: claim, block, clear, then claim vs clear collision.
        bus.claim_valid = 1; bus.claim_r = 5'd7; bus.query_r = 5'd7;
        #1 chk("sb_claim_ready", {31'd0, bus.claim_ready}, 32'd1);
        cyc();
        bus.claim_valid = 0;
        #1;
        chk("sb_busy_set", {31'd0, bus.query_busy}, 32'd1);
        chk("sb_claim_blocked", {31'd0, bus.claim_ready}, 32'd0);
        bus.mem_valid = 1; bus.mem_rd = 5'd7; bus.mem_value = 32'h7777_0001;
        exp_q.push_back('{r: 5'd7, v: 32'h7777_0001, file: 1'b1});
        cyc();
        bus.mem_valid = 0;
        #1;
        chk("sb_busy_during_clear", {31'd0, bus.query_busy}, 32'd1);
        chk("sb_claim_ready_on_clear", {31'd0, bus.claim_ready}, 32'd1);
        cyc();
        chk("sb_busy_cleared", {31'd0, bus.query_busy}, 32'd0);
        bus.claim_valid = 1;
        cyc();
        bus.claim_valid = 0;
        bus.mem_valid = 1; bus.mem_value = 32'h7777_0002;
        exp_q.push_back('{r: 5'd7, v: 32'h7777_0002, file: 1'b1});
        cyc();
        bus.mem_valid = 0;
        bus.claim_valid = 1;
        #1 chk("sb_collide_claim_ready", {31'd0, bus.claim_ready}, 32'd1);
        cyc();
        bus.claim_valid = 0;
        #1 chk("sb_collide_busy_kept", {31'd0, bus.query_busy}, 32'd1);

        // Reset between an ALU handshake and its capture edge.
        cyc();
        bus.alu_valid = 1; bus.alu_rd = 5'd9; bus.alu_value = 32'h0BAD_0BAD;
        #1 chk("rst_mid_alu_ready", {31'd0, bus.alu_ready}, 32'd1);
        #2 rst = 1;
        bus.alu_valid = 0;
        cyc();
        chk("rst_mid_wr_enable", {31'd0, bus.wr_enable}, 32'd0);
        busy_cnt = 0;
        for (int i = 0; i < NUM_GPREGS; i++) begin
            bus.query_r = reg_num'(i);
            #1;
            if (bus.query_busy !== 1'b0) busy_cnt++;
        end
        chk("rst_mid_busy_bits", busy_cnt, 32'd0);
        cyc();
        rst = 0;
        repeat (3) begin
            cyc();
            chk("post_rst_no_write", {31'd0, bus.wr_enable}, 32'd0);
        end

        chk("queue_drained", exp_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
